bcd_multi_digit_seq: RTL and testbench
======================================

// Module: bcd_multi_digit_seq
// PURPOSE
//   Digit-serial sequencer for a single-digit BCD adder: accepts two DIGITS-wide packed BCD
//   operands, runs one decimal digit per cycle LSD-first through a 1-digit BCD add stage,
//   chains the decimal carry, and returns the packed BCD sum with valid/ready handshakes.
//   Sits between operand producers and result consumers wherever wide BCD sums are needed.
// PARAMETERS
//   DIGITS    4   number of BCD digits per operand (>=1); operand width = 4*DIGITS
//   IDX_W     3   width of digit counter; must satisfy 2**IDX_W > DIGITS
// PORTS
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous active-low reset
//   in_valid   in   1          operand set a/b/cin valid
//   in_ready   out  1          block can accept operands (high only in IDLE)
//   a          in   4*DIGITS   packed BCD operand A, digit 0 in [3:0]
//   b          in   4*DIGITS   packed BCD operand B
//   cin        in   1          decimal carry into digit 0
//   out_valid  out  1          sum/cout valid (high only in DONE)
//   out_ready  in   1          consumer accepts result
//   sum        out  4*DIGITS   packed BCD sum
//   cout       out  1          decimal carry out of most significant digit
//   busy       out  1          high in RUN
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE; in_ready=1 after release; out_valid=0, busy=0,
//   sum=0, cout=0, digit counter=0, operand/carry registers=0. Mid-RUN/DONE reset
//   discards the operation; no partial result is ever presented.
// - FSM: IDLE -> RUN on in_valid&&in_ready (a, b, cin latched on that edge, counter=0).
//   RUN: each cycle adds digit[idx] of latched A,B plus carry register; writes digit
//   into sum[4*idx+:4], updates carry, idx++. On the edge with idx==DIGITS-1 -> DONE.
//   DONE -> IDLE on out_valid&&out_ready. No back-to-back accept from DONE.
// - Latency: out_valid rises exactly DIGITS clock edges after the accept edge;
//   throughput one operation per DIGITS+2 cycles minimum.
// - Digit add: t = a_d + b_d + c (5 bits); if t>9 then digit=(t+6)[3:0], c=1,
//   else digit=t[3:0], c=0. cout = carry after last digit.
// - sum and cout are stable and held throughout DONE regardless of out_ready; inputs
//   a/b/cin ignored outside the accept edge. in_valid while not IDLE is ignored (not lost
//   by the block; producer holds it until in_ready).
// - DIGITS==1: RUN lasts one cycle. Non-BCD input digits (>9) produce an undefined digit
//   value but the sequence/timing is unchanged (see CONFIGURATION).
// CONFIGURATION
//   BCD_DIGIT_CHECK_EN defined: extra output port `err` (out, 1): reset 0; cleared on
//     accept; set in RUN if current a or b digit >9; held through DONE with sum/cout.
//     Timing unchanged.
//   Not defined: no err port, no checking logic.
// TESTING
//   1) a=1234,b=5678,cin=0 -> sum=6912,cout=0, out_valid exactly 4 edges after accept
//   2) a=9999,b=0001,cin=0 -> sum=0000,cout=1 (carry ripple through all digits)
//   3) a=0000,b=0000,cin=1 -> sum=0001,cout=0; a=5000,b=5000,cin=0 -> sum=0000,cout=1
//   4) out_ready low 5 cycles in DONE -> sum/cout/out_valid held, in_ready=0; new
//      in_valid ignored until IDLE, then accepted next cycle
//   5) rst_n low at RUN idx=2 -> all outputs reset immediately; next op 0009+0001 -> 0010
//   6) BCD_DIGIT_CHECK_EN: a=12A4,b=0000 -> err=1 at DONE; following 1111+1111 -> err=0

Source files
------------

// File: rtl/bcd_multi_digit_seq.sv
`default_nettype none
// ============================================================================
// Module      : bcd_multi_digit_seq
// Description : Digit-serial BCD adder sequencer. Latches two packed BCD
//               operands, adds one decimal digit per cycle LSD-first with a
//               chained decimal carry, and presents the packed sum with
//               valid/ready handshakes on both sides.
//               Optional macro BCD_DIGIT_CHECK_EN adds an `err` output that
//               flags non-BCD operand digits seen during the operation.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_multi_digit_seq #(
  parameter int DIGITS = 4,
  parameter int IDX_W  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                busy
`ifdef BCD_DIGIT_CHECK_EN
  ,
  output logic                err
`endif
);

  localparam int               C_W        = 4 * DIGITS;
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  // Operands are shifted right one digit per RUN cycle so the active digit
  // always sits in bits [3:0]; no variable-index read mux is needed.
  logic [C_W-1:0]   r_a;
  logic [C_W-1:0]   r_b;
  logic             r_carry;

  logic [3:0]       w_a_dig;
  logic [3:0]       w_b_dig;
  logic [4:0]       w_t;
  logic [3:0]       w_digit;
  logic             w_carry_nxt;

  assign w_a_dig = r_a[3:0];
  assign w_b_dig = r_b[3:0];

  // One-digit BCD add with decimal correction of results above nine
  always_comb begin
    w_t         = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {4'b0000, r_carry};
    w_digit     = w_t[3:0];
    w_carry_nxt = 1'b0;
    if (w_t > 5'd9) begin
      w_digit     = w_t[3:0] + 4'd6;
      w_carry_nxt = 1'b1;
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic w_bad_digit;
  assign w_bad_digit = (w_a_dig > 4'd9) || (w_b_dig > 4'd9);
`endif

  // Control FSM with registered handshake outputs and the digit datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_carry   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
      err       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            r_a      <= a;
            r_b      <= b;
            r_carry  <= cin;
            r_idx    <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            r_state  <= S_RUN;
`ifdef BCD_DIGIT_CHECK_EN
            err      <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
              sum[4*i +: 4] <= w_digit;
            end
          end
          r_a     <= r_a >> 4;
          r_b     <= r_b >> 4;
          r_carry <= w_carry_nxt;
`ifdef BCD_DIGIT_CHECK_EN
          if (w_bad_digit) begin
            err <= 1'b1;
          end
`endif
          if (r_idx == C_LAST_IDX) begin
            r_idx     <= '0;
            cout      <= w_carry_nxt;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_DONE: begin
          // Result stays frozen until the consumer takes it; no accept here
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_multi_digit_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_multi_digit_seq
// Description : Self-checking bench for bcd_multi_digit_seq. Expected sums
//               come from a decimal-integer model and are queued at accept,
//               then popped when the result appears.
//               Define BCD_DIGIT_CHECK_EN to also exercise the err output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_multi_digit_seq;

  localparam int DIGITS = 4;
  localparam int IDX_W  = 3;
  localparam int C_W    = 4 * DIGITS;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [C_W-1:0] a;
  logic [C_W-1:0] b;
  logic           cin;
  logic           out_valid;
  logic           out_ready;
  logic [C_W-1:0] sum;
  logic           cout;
  logic           busy;
`ifdef BCD_DIGIT_CHECK_EN
  logic           err;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [C_W-1:0] sum;
    logic           cout;
  } exp_t;

  exp_t sb_q[$];

  bcd_multi_digit_seq #(
    .DIGITS (DIGITS),
    .IDX_W  (IDX_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef BCD_DIGIT_CHECK_EN
    ,
    .err       (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts, asserts, reports on failure
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: go through plain decimal integers, independent of digit logic
  function automatic exp_t model(input logic [C_W-1:0] x, input logic [C_W-1:0] y,
                                 input logic c);
    exp_t      r;
    longint    xv = 0;
    longint    yv = 0;
    longint    p  = 1;
    longint    tot;
    for (int i = 0; i < DIGITS; i++) begin
      xv += longint'(x[4*i +: 4]) * p;
      yv += longint'(y[4*i +: 4]) * p;
      p  *= 10;
    end
    tot    = xv + yv + longint'(c);
    r.cout = (tot >= p);
    tot    = tot % p;
    r.sum  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r.sum[4*i +: 4] = 4'(tot % 10);
      tot = tot / 10;
    end
    return r;
  endfunction

  function automatic logic [C_W-1:0] rand_bcd();
    logic [C_W-1:0] v;
    for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // Called at +1 after an edge while IDLE; returns at +1 after the accept edge
  task automatic accept(input logic [C_W-1:0] xa, input logic [C_W-1:0] xb, input logic xc);
    in_valid = 1'b1;
    a        = xa;
    b        = xb;
    cin      = xc;
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb_q.push_back(model(xa, xb, xc));
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("in_ready_after_accept", 32'(in_ready), 32'd0);
  endtask

  // Bounded wait for out_valid, then latency and scoreboard comparison
  task automatic wait_done(input string tag);
    int   lat = 0;
    exp_t e;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(DIGITS));
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    if (sb_q.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_sum"}, 32'(sum), 32'(e.sum));
      chk({tag, "_cout"}, 32'(cout), 32'(e.cout));
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_release", 32'(out_valid), 32'd0);
    chk("in_ready_after_release", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [C_W-1:0] held_sum;
    logic           held_cout;
    exp_t           e2;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);

    // Basic add with latency
    accept(16'h1234, 16'h5678, 1'b0);
    wait_done("t1_1234_5678");
    chk("t1_sum_const", 32'(sum), 32'h6912);
    release_result();

    // Carry ripple through all digits
    accept(16'h9999, 16'h0001, 1'b0);
    wait_done("t2_9999_0001");
    release_result();

    // Carry-in only, and top-digit overflow
    accept(16'h0000, 16'h0000, 1'b1);
    wait_done("t3_cin");
    release_result();
    accept(16'h5000, 16'h5000, 1'b0);
    wait_done("t3_5000_5000");
    chk("t3_cout_const", 32'(cout), 32'd1);
    release_result();

    // Maximum operands plus carry-in
    accept(16'h9999, 16'h9999, 1'b1);
    wait_done("t_max");
    release_result();

    // Backpressure in DONE with a competing request held on the input side
    accept(16'h0456, 16'h0789, 1'b0);
    wait_done("t4_first");
    held_sum  = sum;
    held_cout = cout;
    in_valid  = 1'b1;
    a         = 16'h2222;
    b         = 16'h3333;
    cin       = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t4_hold_out_valid", 32'(out_valid), 32'd1);
      chk("t4_hold_in_ready", 32'(in_ready), 32'd0);
      chk("t4_hold_sum", 32'(sum), 32'(held_sum));
      chk("t4_hold_cout", 32'(cout), 32'(held_cout));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("t4_idle_in_ready", 32'(in_ready), 32'd1);
    chk("t4_idle_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb_q.push_back(model(16'h2222, 16'h3333, 1'b1));
    chk("t4_second_accepted", 32'(busy), 32'd1);
    wait_done("t4_second");
    release_result();

    // Asynchronous reset in the middle of RUN
    accept(16'h1234, 16'h5678, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_sum", 32'(sum), 32'd0);
    chk("t5_rst_cout", 32'(cout), 32'd0);
    chk("t5_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    accept(16'h0009, 16'h0001, 1'b0);
    wait_done("t5_0009_0001");
    chk("t5_sum_const", 32'(sum), 32'h0010);
    release_result();

    // Random BCD operands
    for (int i = 0; i < 6; i++) begin
      accept(rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)));
      wait_done("t_rand");
      release_result();
    end

`ifdef BCD_DIGIT_CHECK_EN
    // Non-BCD digit flags err; next clean operation clears it
    accept(16'h12A4, 16'h0000, 1'b0);
    e2 = sb_q.pop_front();
    begin
      int lat = 0;
      while (!out_valid && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("t6_latency", 32'(lat), 32'(DIGITS));
    end
    chk("t6_err_set", 32'(err), 32'd1);
    release_result();
    chk("t6_err_held_idle", 32'(err), 32'd1);
    accept(16'h1111, 16'h1111, 1'b0);
    chk("t6_err_cleared", 32'(err), 32'd0);
    wait_done("t6_1111_1111");
    chk("t6_err_clean", 32'(err), 32'd0);
    release_result();
`else
    e2 = model(16'h0, 16'h0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always terminates
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
